mult_arbiter: RTL and testbench
===============================

// Module: mult_arbiter
// PURPOSE
//  Shares one registered 8-bit sign-magnitude multiplier among NREQ requesters.
//  Round-robin arbitration, valid/ready handshake per requester, one result port with backpressure.
//  Sits between the datapath clients and the multiplier.
//  Returns each product tagged with the ID of the requester that issued it.
// PARAMETERS
//  NREQ   4   number of requesters (2..16)
//  DW     8   operand width; sign-magnitude: bit DW-1 = sign, DW-2:0 = magnitude
//  IDW    $clog2(NREQ)   localparam, result tag width
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous, active-high reset
//  req_valid  in   NREQ       per-requester request valid
//  req_a      in   NREQ*DW    packed operand A, requester i at [i*DW +: DW]
//  req_b      in   NREQ*DW    packed operand B, same packing
//  req_ready  out  NREQ       one-hot accept; at most one bit set
//  res_valid  out  1          result valid
//  res_ready  in   1          result consumer ready
//  res_data   out  2*DW       product {sign, 1'b0, mag_a*mag_b}
//  res_id     out  IDW        index of the requester that owns res_data
//  busy       out  1          high when state != IDLE
// BEHAVIOUR
//  Clock and reset
//   - One clock (clk). Reset (rst) is synchronous and active-high.
//   - After reset: state=IDLE, rr_ptr=0, res_valid=0, res_data=0, res_id=0, busy=0.
//   - While rst=1, req_ready=0.
//  FSM: IDLE -> BUSY -> DONE -> IDLE
//   - IDLE: grant = first req_valid bit at or after rr_ptr (circular); req_ready = grant.
//     - On accept: latch req_a/req_b[grant] into operand regs and grant into id reg;
//       rr_ptr <= grant+1 (wraps NREQ-1 -> 0); go to BUSY.
//     - No valid requests: stay in IDLE; req_ready=0.
//   - BUSY: one cycle. The multiplier registers the product on this edge. req_ready=0. Go to DONE.
//   - DONE: res_valid=1; res_data and res_id are held stable. req_ready=0.
//     - res_ready=1: complete the transfer, go to IDLE.
//   - Latency: accept edge to res_valid high is 2 cycles. Peak throughput is 1 op per 3 cycles.
//  Handshake
//   - A requester holds valid and operands until its req_ready is seen.
//   - Dropping req_valid while not granted is legal; there is no penalty.
//   - res_valid never deasserts without res_ready.
//  Arithmetic
//   - sign = a[DW-1] ^ b[DW-1]; magnitude = a[DW-2:0] * b[DW-2:0], unsigned, 2*DW-2 bits.
//   - Bit 2*DW-2 is always 0.
//   - A zero magnitude with opposite signs yields negative zero (0x8000). It is not normalised.
//  Boundaries
//   - Simultaneous requests: exactly one grant; the others wait.
//   - rr_ptr wraps at NREQ.
//   - Reset in BUSY or DONE: the in-flight op is discarded and no result is emitted.
//   - A single requester always wins immediately, regardless of rr_ptr.
// CONFIGURATION
//  MULT_ARB_FIXED_PRIO_EN
//   - Defined: fixed priority; the lowest index wins. rr_ptr is removed and treated as 0.
//   - Undefined (default): round-robin as described above.
// STRUCTURE
//  Package mult_arb_pkg
//   - typedef enum {IDLE, BUSY, DONE} arb_state_t
//   - DW default
//   - function rr_pick(valid, ptr) -> one-hot grant
//  Sub-module sm_mult8
//   - Registered sign-magnitude multiplier: clk, a, b, out.
//   - Product registered on every clk edge; no enable, no reset.
//   - Instantiated once, fed from the operand regs.
// TESTING
//  1. Req0 a=0x83 b=0x05 -> 2 cycles later res_valid=1, res_data=0x800F, res_id=0.
//  2. a=0xFF b=0x7F -> 0xBF01; a=0x7F b=0x7F -> 0x3F01; a=0x80 b=0x05 -> 0x8000.
//  3. All 4 req_valid held high -> grant order 0,1,2,3,0.
//     With MULT_ARB_FIXED_PRIO_EN -> 0,0,0.
//  4. res_ready=0 for 5 cycles in DONE -> res_data/res_id stable, req_ready=0,
//     completes on the cycle res_ready=1.
//  5. rst=1 during BUSY -> next cycle res_valid=0, busy=0, no result appears later,
//     next grant starts from requester 0.
//  6. Req2 valid alone with rr_ptr=3 -> req_ready=0b0100 on the same cycle; rr_ptr becomes 3.

Source files
------------

// File: rtl/mult_arbiter_pkg.sv
// Shared types and grant helpers for the multiplier arbiter.
// Grant helpers are sized for the largest supported requester count and are zero-extended by callers.
package mult_arb_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int NREQ_MAX   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // First set bit of valid at or after ptr, walking circularly over n requesters.
  function automatic logic [NREQ_MAX-1:0] rr_pick(input logic [NREQ_MAX-1:0] valid,
                                                  input logic [3:0]          ptr,
                                                  input int                  n);
    logic [NREQ_MAX-1:0] grant;
    logic                found;
    logic [3:0]          idx;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ_MAX; i++) begin
      idx = 4'((int'(ptr) + i) % n);
      if (i < n && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

  function automatic logic [3:0] oh_idx(input logic [NREQ_MAX-1:0] oh);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < NREQ_MAX; i++) begin
      if (oh[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Request/result bundle between the datapath clients (master) and the arbiter (slave).
interface mult_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = mult_arb_pkg::DW_DEFAULT
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic               res_valid;
  logic               res_ready;
  logic [2*DW-1:0]    res_data;
  logic [IDW-1:0]     res_id;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/mult_arbiter_sm_mult8.sv
// Registered sign-magnitude multiplier: out = {sa^sb, 1'b0, |a|*|b|}, one cycle latency.
// Captures on every clock edge; no enable and no reset.
module sm_mult8
  import mult_arb_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [2*DW-1:0] out
);

  logic [2*DW-3:0] mag_a;
  logic [2*DW-3:0] mag_b;
  logic [2*DW-3:0] mag;

  assign mag_a = {{(DW-1){1'b0}}, a[DW-2:0]};
  assign mag_b = {{(DW-1){1'b0}}, b[DW-2:0]};
  assign mag   = mag_a * mag_b;

  // Zero magnitude keeps its sign: negative zero is passed through as-is.
  always_ff @(posedge clk) begin
    out <= {a[DW-1] ^ b[DW-1], 1'b0, mag};
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin share of one sign-magnitude multiplier among NREQ requesters (MULT_ARB_FIXED_PRIO_EN: lowest index wins).
// Accept to res_valid is 2 cycles; one op in flight, so peak rate is one op per 3 cycles.
// res_valid holds with stable data/id until res_ready; no request is accepted meanwhile.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  mult_arbiter_if.slave bus,
  output logic          busy
);

  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_BUSY = 2'(BUSY);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [1:0]          state;
  logic [IDW-1:0]      ptr;
  logic [NREQ_MAX-1:0] grant_w;
  logic [NREQ-1:0]     grant;
  logic [IDW-1:0]      grant_idx;
  logic                accept;
  logic [DW-1:0]       op_a;
  logic [DW-1:0]       op_b;
  logic [IDW-1:0]      id_q;
  logic [2*DW-1:0]     prod;
  logic                unused_grant;

  assign grant_w      = rr_pick(NREQ_MAX'(bus.req_valid), 4'(ptr), NREQ);
  assign grant        = grant_w[NREQ-1:0];
  assign grant_idx    = IDW'(oh_idx(grant_w));
  assign unused_grant = ^grant_w;
  assign accept       = (state == ST_IDLE) && (|grant);

`ifdef MULT_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IDW-1:0] rr_ptr;

  // Pointer moves just past the winner so it becomes the lowest priority next round.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign ptr = rr_ptr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      id_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_a  <= bus.req_a[int'(grant_idx)*DW +: DW];
            op_b  <= bus.req_b[int'(grant_idx)*DW +: DW];
            id_q  <= grant_idx;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: state <= ST_DONE;
        ST_DONE: begin
          if (bus.res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand regs stay put until the next accept, so the product is stable through DONE.
  sm_mult8 #(.DW(DW)) u_mult (
    .clk (clk),
    .a   (op_a),
    .b   (op_b),
    .out (prod)
  );

  assign bus.req_ready = (state == ST_IDLE && !rst) ? grant : '0;
  assign bus.res_valid = (state == ST_DONE);
  assign bus.res_data  = (state == ST_DONE) ? prod : '0;
  assign bus.res_id    = id_q;
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized and directed bench for mult_arbiter against a transaction-level reference model.
module tb_mult_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   failures = 0;
  int   mptr = 0;

  mult_arbiter_if #(.NREQ(4), .DW(8)) bus ();

  mult_arbiter #(.NREQ(4), .DW(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
    int ma, mb, s;
    ma = int'(a) % 128;
    mb = int'(b) % 128;
    s  = (int'(a) / 128) ^ (int'(b) / 128);
    return 16'(s * 32768 + ma * mb);
  endfunction

  function automatic int ref_pick(input logic [3:0] v, input int ptr);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = (ptr + k) % 4;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int next_ptr(input int g);
`ifdef MULT_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (g + 1) % 4;
`endif
  endfunction

  task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
    logic [31:0] ta, tb;
    ta = bus.req_a;
    tb = bus.req_b;
    ta[id*8 +: 8] = a;
    tb[id*8 +: 8] = b;
    bus.req_a = ta;
    bus.req_b = tb;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_a = $urandom;
    bus.req_b = $urandom;
    bus.res_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (bus.res_data !== 16'h0) begin failures++; $display("FAIL reset_res_data got=%h exp=0000", bus.res_data); end
    checks++; if (bus.res_id !== 2'd0) begin failures++; $display("FAIL reset_res_id got=%0d exp=0", bus.res_id); end
    checks++; if (bus.req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
    bus.req_valid = '0;
    rst = 1'b0;
    mptr = 0;
  endtask

  task automatic single_op(input int id, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] exp;
    exp = ref_prod(a, b);
    @(negedge clk);
    bus.req_valid = 4'(1 << id);
    set_ops(id, a, b);
    bus.res_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'(1 << id)) begin failures++; $display("FAIL single_grant id=%0d got=%b exp=%b", id, bus.req_ready, 4'(1 << id)); end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    checks++; if (busy !== 1'b1 || bus.res_valid !== 1'b0) begin failures++; $display("FAIL single_busy_phase busy=%b res_valid=%b exp busy=1 res_valid=0", busy, bus.res_valid); end
    @(negedge clk);
    #1;
    checks++; if (bus.res_valid !== 1'b1) begin failures++; $display("FAIL single_res_valid got=%b exp=1", bus.res_valid); end
    checks++; if (bus.res_data !== exp) begin failures++; $display("FAIL single_res_data a=%h b=%h got=%h exp=%h", a, b, bus.res_data, exp); end
    checks++; if (bus.res_id !== 2'(id)) begin failures++; $display("FAIL single_res_id got=%0d exp=%0d", bus.res_id, id); end
    @(negedge clk);
    #1;
    checks++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_complete res_valid=%b busy=%b exp 0 0", bus.res_valid, busy); end
    mptr = next_ptr(id);
  endtask

  task automatic test_products;
    do_reset();
    single_op(0, 8'h83, 8'h05);
    single_op(1, 8'hFF, 8'h7F);
    single_op(2, 8'h7F, 8'h7F);
    single_op(3, 8'h80, 8'h05);
    single_op(1, 8'h00, 8'h80);
    single_op(2, 8'h01, 8'h81);
  endtask

  task automatic test_grant_order;
    int exp_order [5];
    bit found;
`ifdef MULT_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    @(negedge clk);
    bus.req_a = $urandom;
    bus.req_b = $urandom;
    bus.res_ready = 1'b1;
    bus.req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      found = 1'b0;
      for (int t = 0; t < 8 && !found; t++) begin
        #1;
        if (bus.req_ready !== 4'b0) found = 1'b1;
        else @(negedge clk);
      end
      checks++;
      if (!found) begin
        failures++; $display("FAIL grant_order_timeout n=%0d got=none exp=%0d", n, exp_order[n]);
      end else if (bus.req_ready !== 4'(1 << exp_order[n])) begin
        failures++; $display("FAIL grant_order n=%0d got=%b exp=%b", n, bus.req_ready, 4'(1 << exp_order[n]));
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [15:0] exp;
    do_reset();
    exp = ref_prod(8'h9A, 8'h3C);
    @(negedge clk);
    bus.req_valid = 4'b0010;
    set_ops(1, 8'h9A, 8'h3C);
    bus.res_ready = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL bp_grant got=%b exp=0010", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== exp || bus.res_id !== 2'd1 || bus.req_ready !== 4'b0) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d valid=%b data=%h id=%0d ready=%b exp valid=1 data=%h id=1 ready=0000",
                 i, bus.res_valid, bus.res_data, bus.res_id, bus.req_ready, exp);
      end
    end
    @(negedge clk);
    bus.res_ready = 1'b1;
    #1;
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== exp) begin failures++; $display("FAIL bp_release valid=%b data=%h exp valid=1 data=%h", bus.res_valid, bus.res_data, exp); end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    checks++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_done valid=%b busy=%b exp 0 0", bus.res_valid, busy); end
    mptr = next_ptr(1);
  endtask

  task automatic test_reset_busy;
    do_reset();
    @(negedge clk);
    bus.req_valid = 4'b0010;
    set_ops(1, 8'h12, 8'h34);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    #1;
    checks++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_busy_state valid=%b busy=%b exp 0 0", bus.res_valid, busy); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL rst_busy_ghost cycle=%0d got=%b exp=0", i, bus.res_valid); end
    end
    bus.req_valid = 4'hF;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL rst_busy_next_grant got=%b exp=0001", bus.req_ready); end
    bus.req_valid = '0;
  endtask

  task automatic test_lone_requester;
    int g;
    do_reset();
    single_op(2, 8'h55, 8'h0A);
    @(negedge clk);
    bus.req_valid = 4'b0100;
    set_ops(2, 8'h21, 8'hA3);
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL lone_grant got=%b exp=0100", bus.req_ready); end
    mptr = next_ptr(2);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    bus.req_valid = 4'hF;
    #1;
    g = ref_pick(4'hF, mptr);
    checks++; if (bus.req_ready !== 4'(1 << g)) begin failures++; $display("FAIL lone_ptr_after got=%b exp=%b", bus.req_ready, 4'(1 << g)); end
    bus.req_valid = '0;
  endtask

  task automatic test_random;
    bit          hv [4];
    logic [7:0]  ha [4];
    logic [7:0]  hb [4];
    bit          infl;
    int          age, eid, g, ptr;
    logic [15:0] edat;
    logic [3:0]  v, exp_rdy;
    do_reset();
    ptr  = mptr;
    infl = 1'b0;
    age  = 0;
    eid  = 0;
    edat = '0;
    for (int r = 0; r < 4; r++) begin hv[r] = 1'b0; ha[r] = '0; hb[r] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int r = 0; r < 4; r++) begin
        if (!hv[r] && ($urandom % 3 == 0)) begin
          hv[r] = 1'b1; ha[r] = 8'($urandom); hb[r] = 8'($urandom);
        end else if (hv[r] && ($urandom % 8 == 0)) begin
          hv[r] = 1'b0;
        end
        v[r] = hv[r];
      end
      bus.req_valid = v;
      bus.req_a     = {ha[3], ha[2], ha[1], ha[0]};
      bus.req_b     = {hb[3], hb[2], hb[1], hb[0]};
      bus.res_ready = 1'($urandom % 2);
      #1;
      g = infl ? -1 : ref_pick(v, ptr);
      exp_rdy = (g < 0) ? 4'b0 : 4'(1 << g);
      checks++; if (bus.req_ready !== exp_rdy) begin failures++; $display("FAIL rand_req_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_rdy); end
      checks++; if (bus.res_valid !== (infl && age >= 1)) begin failures++; $display("FAIL rand_res_valid cyc=%0d got=%b exp=%b", cyc, bus.res_valid, infl && age >= 1); end
      if (infl && age >= 1) begin
        checks++;
        if (bus.res_data !== edat || bus.res_id !== 2'(eid)) begin
          failures++; $display("FAIL rand_result cyc=%0d data=%h id=%0d exp data=%h id=%0d", cyc, bus.res_data, bus.res_id, edat, eid);
        end
      end
      if (g >= 0) begin
        infl  = 1'b1;
        age   = 0;
        eid   = g;
        edat  = ref_prod(ha[g], hb[g]);
        ptr   = next_ptr(g);
        hv[g] = 1'b0;
      end else if (infl) begin
        if (age >= 1 && bus.res_ready) infl = 1'b0;
        else age = 1;
      end
    end
    @(negedge clk);
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    test_reset();
    test_products();
    test_grant_order();
    test_backpressure();
    test_reset_busy();
    test_lone_requester();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
